// File: rtl/hack_cpu_ctrl.sv
// Execute/control stage around the 16-bit Hack ALU: decodes A/C instructions,
// owns A, D and PC, resolves jumps, and stalls on the data-memory ready handshake.
`timescale 1ns/1ps

module hack_cpu_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  input  logic [15:0]      in_m,
  input  logic             mem_ready,
  output logic [15:0]      alu_x,
  output logic [15:0]      alu_y,
  output logic [5:0]       alu_ctl,
  input  logic [15:0]      alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng,
  output logic [15:0]      out_m,
  output logic             write_m,
  output logic [14:0]      address_m,
  output logic [14:0]      pc,
  output logic             stall,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  // Wide enough to hold MEM_TIMEOUT; with MEM_TIMEOUT=0 the counter is never compared.
  localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(MEM_TIMEOUT);

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0]        ir_buf_q;
  logic [15:0]        a_q, d_q;
  logic [14:0]        pc_q;
  logic [CNT_W-1:0]   retired_q;

  logic [15:0] ir;
  logic        is_c, a_bit, dest_a, dest_d, dest_m;
  logic        memop, jmp;
  logic        retire, latch, stall_raw, valid_in_state;

  // Decode: while waiting, the latched word is the instruction in flight.
  assign ir     = (state_q == S_WAIT) ? ir_buf_q : instr;
  assign is_c   = ir[15];
  assign a_bit  = ir[12];
  assign dest_a = is_c & ir[5];
  assign dest_d = is_c & ir[4];
  assign dest_m = is_c & ir[3];
  assign memop  = is_c & (a_bit | ir[3]);
  assign jmp    = is_c & ((ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr));

  assign alu_x     = d_q;
  assign alu_y     = (is_c & a_bit) ? in_m : a_q;
  assign alu_ctl   = is_c ? ir[11:6] : 6'd0;
  assign out_m     = alu_out;
  assign address_m = a_q[14:0];
  assign pc        = pc_q;
  assign retired   = retired_q;
  assign fault     = (state_q == S_FAULT);

  // Reset is synchronous, but a pending write must not be seen by memory in the reset cycle.
  assign write_m = dest_m & valid_in_state & ~fault & ~reset;
  assign stall   = stall_raw & ~reset;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    retire         = 1'b0;
    latch          = 1'b0;
    stall_raw      = 1'b0;
    valid_in_state = 1'b0;
    case (state_q)
      S_RUN: begin
        valid_in_state = instr_valid;
        if (instr_valid) begin
          if (!memop || mem_ready) begin
            retire = 1'b1;
          end else begin
            latch      = 1'b1;
            wait_cnt_d = WCNT_W'(1);
            state_d    = S_WAIT;
            stall_raw  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        valid_in_state = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_RUN;
        end else if (MEM_TIMEOUT != 0 && wait_cnt_q == TIMEOUT_V) begin
          state_d   = S_FAULT;
          stall_raw = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          stall_raw  = 1'b1;
        end
      end
      S_FAULT: begin
        stall_raw = 1'b1;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the jump target relies on this reading the old A.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
      a_q        <= '0;
      d_q        <= '0;
      pc_q       <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (retire) begin
        if (!is_c) begin
          a_q <= {1'b0, ir[14:0]};
        end else begin
          if (dest_a) a_q <= alu_out;
          if (dest_d) d_q <= alu_out;
        end
        pc_q      <= jmp ? a_q[14:0] : pc_q + 15'd1;
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // NOTE: the wait buffer has no reset; it is only read in WAIT, which is
  // always entered through a cycle that loads it.
  always_ff @(posedge clk) begin
    if (latch) ir_buf_q <= instr;
  end

endmodule
